// File: rtl/tic_tac_toe_ai_player.sv
// Computer-side move generator for tic-tac-toe.
// Takes a snapshot of the board on start. It then scans the eight lines one per cycle,
// first for a winning move and then (when TTT_AI_BLOCK_EN is defined) for a blocking
// move. If neither scan hits, it falls back to a static preference order.
// The result is a one-cycle move_valid or no_move strobe.
// Optional feature macro: TTT_AI_BLOCK_EN (opponent-blocking scan; absent by default).
module tic_tac_toe_ai_player #(
  parameter logic [1:0] AI_CODE       = 2'b10,
  parameter logic [1:0] OPP_CODE      = 2'b01,
  parameter bit         PREFER_CENTER = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic [3:0]  move_position,
  output logic        move_valid,
  output logic        no_move,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StScanWin,
`ifdef TTT_AI_BLOCK_EN
    StScanBlock,
`endif
    StPick,
    StDone
  } state_e;

  // Static preference tables; entry j sits at bits [4j+3:4j].
  localparam logic [35:0] CenterOrder = {4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4};
  localparam logic [35:0] CornerOrder = {4'd7, 4'd5, 4'd3, 4'd1, 4'd4, 4'd8, 4'd6, 4'd2, 4'd0};
  localparam logic [35:0] PickOrder   = PREFER_CENTER ? CenterOrder : CornerOrder;

  state_e      state;
  logic [2:0]  line_k;
  logic [17:0] snapshot;

  logic [3:0]  idx_a, idx_b, idx_c;
  logic [1:0]  cell_a, cell_b, cell_c;
  logic [1:0]  scan_code;
  logic        line_hit;
  logic [3:0]  line_pos;
  logic        pick_hit;
  logic [3:0]  pick_pos;

  // Three cell indices of line k, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] k);
    case (k)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

  // Evaluate the current line: two cells of scan_code plus one empty cell is a hit.
  always_comb begin
    {idx_a, idx_b, idx_c} = line_cells(line_k);
    cell_a = cell_at(snapshot, idx_a);
    cell_b = cell_at(snapshot, idx_b);
    cell_c = cell_at(snapshot, idx_c);
`ifdef TTT_AI_BLOCK_EN
    scan_code = (state == StScanBlock) ? OPP_CODE : AI_CODE;
`else
    scan_code = AI_CODE;
`endif
    line_hit = 1'b0;
    line_pos = idx_a;
    if (cell_a == 2'b00 && cell_b == scan_code && cell_c == scan_code) begin
      line_hit = 1'b1;
      line_pos = idx_a;
    end else if (cell_b == 2'b00 && cell_a == scan_code && cell_c == scan_code) begin
      line_hit = 1'b1;
      line_pos = idx_b;
    end else if (cell_c == 2'b00 && cell_a == scan_code && cell_b == scan_code) begin
      line_hit = 1'b1;
      line_pos = idx_c;
    end
  end

  // First empty cell in static order; walking backwards lets the earliest entry win.
  always_comb begin
    pick_hit = 1'b0;
    pick_pos = 4'd0;
    for (int j = 8; j >= 0; j--) begin
      if (cell_at(snapshot, PickOrder[4*j +: 4]) == 2'b00) begin
        pick_hit = 1'b1;
        pick_pos = PickOrder[4*j +: 4];
      end
    end
  end

  // Move-selection FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      line_k        <= 3'd0;
      snapshot      <= 18'd0;
      move_position <= 4'd0;
      move_valid    <= 1'b0;
      no_move       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            snapshot <= board;
            line_k   <= 3'd0;
            busy     <= 1'b1;
            state    <= StScanWin;
          end
        end
        StScanWin: begin
          if (line_hit) begin
            move_position <= line_pos;
            move_valid    <= 1'b1;
            state         <= StDone;
          end else if (line_k == 3'd7) begin
            line_k <= 3'd0;
`ifdef TTT_AI_BLOCK_EN
            state  <= StScanBlock;
`else
            state  <= StPick;
`endif
          end else begin
            line_k <= line_k + 3'd1;
          end
        end
`ifdef TTT_AI_BLOCK_EN
        StScanBlock: begin
          if (line_hit) begin
            move_position <= line_pos;
            move_valid    <= 1'b1;
            state         <= StDone;
          end else if (line_k == 3'd7) begin
            line_k <= 3'd0;
            state  <= StPick;
          end else begin
            line_k <= line_k + 3'd1;
          end
        end
`endif
        StPick: begin
          // A full board keeps the previous move_position and flags no_move instead.
          if (pick_hit) begin
            move_position <= pick_pos;
            move_valid    <= 1'b1;
          end else begin
            no_move <= 1'b1;
          end
          state <= StDone;
        end
        StDone: begin
          move_valid <= 1'b0;
          no_move    <= 1'b0;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tic_tac_toe_ai_player.sv
// Self-checking bench for tic_tac_toe_ai_player.
// Two instances share the stimulus: one with centre-first ordering and one with
// corner-first ordering. Expected results are queued when a start is issued and
// checked when the strobe appears.
module tb_tic_tac_toe_ai_player;

  localparam logic [1:0] Ai  = 2'b10;
  localparam logic [1:0] Opp = 2'b01;
`ifdef TTT_AI_BLOCK_EN
  localparam int PickLat     = 17;
  localparam int AbortEdges  = 11;
`else
  localparam int PickLat     = 9;
  localparam int AbortEdges  = 5;
`endif

  typedef struct {
    logic [3:0] pos;
    bit         nm;
    int         lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] board;
  logic [3:0]  pos0, pos1;
  logic        mv0, mv1, nm0, nm1, busy0, busy1;

  int total = 0;
  int bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  tic_tac_toe_ai_player #(
    .AI_CODE      (2'b10),
    .OPP_CODE     (2'b01),
    .PREFER_CENTER(1'b1)
  ) dut_center (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .board        (board),
    .move_position(pos0),
    .move_valid   (mv0),
    .no_move      (nm0),
    .busy         (busy0)
  );

  tic_tac_toe_ai_player #(
    .AI_CODE      (2'b10),
    .OPP_CODE     (2'b01),
    .PREFER_CENTER(1'b0)
  ) dut_corner (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .board        (board),
    .move_position(pos1),
    .move_valid   (mv1),
    .no_move      (nm1),
    .busy         (busy1)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] put(input logic [17:0] b, input int i, input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  // Issue one start, then wait for the strobe and check it against the queued expectation.
  task automatic run_move(input string name, input logic [17:0] b, input logic [3:0] p0,
                          input logic [3:0] p1, input bit nm, input int lat);
    exp_t e0, e1;
    bit   found;
    int   c;
    @(negedge clock);
    board = b;
    start = 1'b1;
    q0.push_back('{pos: p0, nm: nm, lat: lat});
    q1.push_back('{pos: p1, nm: nm, lat: lat});
    @(posedge clock);
    #1;
    start = 1'b0;
    // The scan must run on the snapshot; this board would give no_move if it leaked in.
    board = 18'h3FFFF;
    total++;
    if (busy0 !== 1'b1) begin
      $display("FAIL %s busy_after_start got=%b want=1", name, busy0);
      bad++;
    end
    found = 1'b0;
    c = 0;
    while (!found && c < 40) begin
      c++;
      @(posedge clock);
      #1;
      if (mv0 || nm0 || mv1 || nm1) begin
        found = 1'b1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        total++;
        if (c !== e0.lat) begin
          $display("FAIL %s latency got=%0d want=%0d", name, c, e0.lat);
          bad++;
        end
        total++;
        if (pos0 !== e0.pos || pos1 !== e1.pos) begin
          $display("FAIL %s position got=%0d/%0d want=%0d/%0d", name, pos0, pos1, e0.pos,
                   e1.pos);
          bad++;
        end
        total++;
        if (nm0 !== e0.nm || nm1 !== e1.nm) begin
          $display("FAIL %s no_move got=%b/%b want=%b", name, nm0, nm1, e0.nm);
          bad++;
        end
        total++;
        if (mv0 !== !e0.nm || mv1 !== !e1.nm) begin
          $display("FAIL %s move_valid got=%b/%b want=%b", name, mv0, mv1, !e0.nm);
          bad++;
        end
        total++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
          $display("FAIL %s busy_on_strobe got=%b/%b want=1", name, busy0, busy1);
          bad++;
        end
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=no_strobe want=strobe_at_%0d", name, lat);
      q0.delete();
      q1.delete();
    end
    @(posedge clock);
    #1;
    total++;
    if ({mv0, nm0, busy0, mv1, nm1, busy1} !== 6'b0) begin
      $display("FAIL %s after_strobe got=%b want=000000", name,
               {mv0, nm0, busy0, mv1, nm1, busy1});
      bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    board = 18'd0;
    #12;
    total++;
    if ({pos0, mv0, nm0, busy0} !== 7'd0 || {pos1, mv1, nm1, busy1} !== 7'd0) begin
      $display("FAIL reset_values got=%b/%b want=0", {pos0, mv0, nm0, busy0},
               {pos1, mv1, nm1, busy1});
      bad++;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_win();
    run_move("win_line0", put(put(18'd0, 0, Ai), 1, Ai), 4'd2, 4'd2, 1'b0, 1);
    // Lines 1 and 2 both qualify; the lower index must be chosen.
    run_move("win_lowest_line", put(put(put(put(18'd0, 3, Ai), 4, Ai), 6, Ai), 7, Ai),
             4'd5, 4'd5, 1'b0, 2);
  endtask

  task automatic test_block();
    logic [17:0] b;
    b = put(put(18'd0, 3, Opp), 4, Opp);
`ifdef TTT_AI_BLOCK_EN
    run_move("block_line1", b, 4'd5, 4'd5, 1'b0, 10);
`else
    run_move("block_absent_pick", b, 4'd0, 4'd0, 1'b0, 9);
`endif
    b = put(put(put(put(18'd0, 6, Ai), 7, Ai), 0, Opp), 1, Opp);
    run_move("win_beats_block", b, 4'd8, 4'd8, 1'b0, 3);
  endtask

  task automatic test_static_order();
    run_move("pick_empty", 18'd0, 4'd4, 4'd0, 1'b0, PickLat);
    run_move("pick_centre_taken", put(18'd0, 4, Opp), 4'd0, 4'd0, 1'b0, PickLat);
  endtask

  task automatic test_full_board();
    logic [17:0] b;
    // Cells 0..8: 10,01,10,10,01,01,01,10,10
    b = {2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    // Position must keep the previous decision (0 in both instances).
    run_move("full_board", b, 4'd0, 4'd0, 1'b1, PickLat);
  endtask

  task automatic test_back_to_back();
    int exp_cyc[$];
    int got;
    @(negedge clock);
    board = put(put(18'd0, 0, Ai), 1, Ai);
    start = 1'b1;
    exp_cyc.push_back(1);
    exp_cyc.push_back(4);
    @(posedge clock);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clock);
      #1;
      if (mv0) begin
        got = (exp_cyc.size() > 0) ? exp_cyc.pop_front() : -1;
        total++;
        if (c !== got || pos0 !== 4'd2) begin
          $display("FAIL back_to_back strobe got=cyc%0d/pos%0d want=cyc%0d/pos2", c, pos0, got);
          bad++;
        end
      end
    end
    start = 1'b0;
    total++;
    if (exp_cyc.size() !== 0) begin
      $display("FAIL back_to_back missing_strobes got=%0d_left want=0", exp_cyc.size());
      bad++;
    end
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (busy0 !== 1'b0) begin
      $display("FAIL back_to_back idle_busy got=%b want=0", busy0);
      bad++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int strobes;
    @(negedge clock);
    board = 18'd0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (AbortEdges) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({pos0, mv0, nm0, busy0} !== 7'd0 || {pos1, mv1, nm1, busy1} !== 7'd0) begin
      $display("FAIL reset_mid_scan got=%b/%b want=0", {pos0, mv0, nm0, busy0},
               {pos1, mv1, nm1, busy1});
      bad++;
    end
    @(negedge clock);
    reset = 1'b0;
    strobes = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (mv0 || nm0 || busy0) strobes++;
    end
    total++;
    if (strobes !== 0) begin
      $display("FAIL reset_mid_scan late_activity got=%0d want=0", strobes);
      bad++;
    end
    run_move("after_reset_new_board", put(put(18'd0, 4, Ai), 6, Ai), 4'd2, 4'd2, 1'b0, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_win();
    test_block();
    test_static_order();
    test_full_board();
    test_back_to_back();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
